// File: rtl/mem_access_unit.sv
// mem_access_unit: req/ack memory stage with load data register, status and ack timeout
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  // Next-state: accept in IDLE, then ack (priority) or timeout abort or count in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      if (start) begin
        addr_d  = addr;
        wdata_d = wdata;
        we_d    = write_en;
        req_d   = 1'b1;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
    end else if (mem_ack) begin
      rdata_d = we_q ? rdata_q : mem_rdata;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
    end else if (cnt_q == CNT_LAST) begin
      req_d   = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  // State and registered outputs; active-low synchronous reset drops any transaction
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule
